// File: rtl/circuit_test_pkg.sv
// Shared types and sizes for the 3-input truth-table checker.
package circuit_test_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: counts while enabled, terminal flag when the count reaches TC.
module tt_settle_timer
  import circuit_test_pkg::*;
#(
  parameter int unsigned TC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == CNT_W'(TC));

endmodule

// File: rtl/circuit_tt_checker.sv
// Drives all eight {a,b,c} vectors into a circuit under test, samples y after a
// settle window and records mismatches against an expected truth table.
module circuit_tt_checker
  import circuit_test_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0] EXP_TT        = 8'b1110_1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               y,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [VEC_W-1:0]   first_fail_idx
);

  state_e             state_q;
  logic [VEC_W-1:0]   idx_q;
  logic [VEC_W-1:0]   vec_q;
  logic               busy_q, done_q, pass_q;
  logic [NUM_VEC-1:0] fail_mask_q;
  logic [CNT_W-1:0]   fail_cnt_q;
  logic [VEC_W-1:0]   first_fail_q;

  logic               settle_tc;
  logic               miss;
  logic [CNT_W-1:0]   fail_cnt_d;

  tt_settle_timer #(
    .TC (SETTLE_CYCLES - 1)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != SETTLE),
    .en_i  (state_q == SETTLE),
    .tc_o  (settle_tc)
  );

  assign miss       = (y != EXP_TT[idx_q]);
  assign fail_cnt_d = fail_cnt_q + {{(CNT_W-1){1'b0}}, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_mask_q  <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            fail_mask_q  <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            idx_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            vec_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (settle_tc) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          // abort wins over the compare: the vector in flight is dropped
          if (abort) begin
            vec_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (miss) begin
              fail_mask_q[idx_q] <= 1'b1;
              fail_cnt_q         <= fail_cnt_d;
              if (fail_cnt_q == '0) first_fail_q <= idx_q;
            end
            if (idx_q == VEC_W'(NUM_VEC - 1)) begin
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_cnt_d == '0);
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              vec_q   <= idx_q + 1'b1;
              state_q <= SETTLE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a              = vec_q[2];
  assign b              = vec_q[1];
  assign c              = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_mask      = fail_mask_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_circuit_tt_checker.sv
// Four checker instances (settle 2/2/1/15, one with vector 7 inverted) each
// driving a table-based fake circuit; results compared against a run-level model.
module tb_circuit_tt_checker;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      start_v = '0;
  logic [3:0]      abort_v = '0;
  logic [3:0]      y_w, a_w, b_w, c_w, busy_w, done_w, pass_w;
  logic [3:0][7:0] fm_w;
  logic [3:0][3:0] cnt_w;
  logic [3:0][2:0] ffi_w;
  logic [7:0]      dut_tt [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int s_of(input int id);
    case (id)
      2:       return 1;
      3:       return 15;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] e_of(input int id);
    return (id == 1) ? 8'h68 : 8'hE8;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    circuit_tt_checker #(
      .SETTLE_CYCLES ((g == 2) ? 1 : (g == 3) ? 15 : 2),
      .EXP_TT        ((g == 1) ? 8'h68 : 8'hE8)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start_v[g]),
      .abort          (abort_v[g]),
      .y              (y_w[g]),
      .a              (a_w[g]),
      .b              (b_w[g]),
      .c              (c_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .pass           (pass_w[g]),
      .fail_mask      (fm_w[g]),
      .fail_cnt       (cnt_w[g]),
      .first_fail_idx (ffi_w[g])
    );
  end

  // Fake circuit under test: y is a lookup in a per-instance truth table.
  always_comb begin
    y_w = '0;
    for (int i = 0; i < 4; i++) y_w[i] = dut_tt[i][{a_w[i], b_w[i], c_w[i]}];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs(input int id);
    return {9'd0, a_w[id], b_w[id], c_w[id], busy_w[id], done_w[id], pass_w[id],
            fm_w[id], cnt_w[id], ffi_w[id]};
  endfunction

  // One run on instance id. abort_k / rst_k: edge (relative to start edge E0)
  // at which abort is sampled / reset is pulsed; 0 means none.
  task automatic run(input int id, input logic [7:0] tt, input int abort_k,
                     input int rst_k, input bit busy_starts);
    int S, L, bad, dones, done_at, lim, vec_exp;
    bit aborted;
    logic [7:0] m, e;
    int cnt_exp, ffi_exp;
    S = s_of(id); L = 8 * (S + 1); e = e_of(id);
    bad = 0; dones = 0; done_at = -1;
    lim = (abort_k == 0) ? L + 1 : abort_k - 1;
    dut_tt[id] = tt;
    @(negedge clk); start_v[id] = 1'b1;
    @(posedge clk); #1; start_v[id] = 1'b0;
    if (busy_w[id] !== 1'b1 || {a_w[id], b_w[id], c_w[id]} !== 3'd0) bad++;
    for (int k = 1; k <= L + 3; k++) begin
      if (k == rst_k) begin
        rst_n = 1'b0; #1;
        chk("rst_midrun_outputs", all_outs(id), 32'd0);
        rst_n = 1'b1;
        return;
      end
      abort_v[id] = (k == abort_k);
      start_v[id] = busy_starts && (k <= lim) && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      abort_v[id] = 1'b0; start_v[id] = 1'b0;
      aborted = (abort_k != 0) && (k >= abort_k);
      if (done_w[id]) begin dones++; if (done_at < 0) done_at = k; end
      if (aborted) begin
        if (busy_w[id] || done_w[id] || {a_w[id], b_w[id], c_w[id]} != 3'd0) bad++;
      end else begin
        if (busy_w[id] !== (k < L)) bad++;
        if (done_w[id] !== (k == L)) bad++;
        vec_exp = (k < L) ? k / (S + 1) : 0;
        if (k != L && {a_w[id], b_w[id], c_w[id]} !== 3'(vec_exp)) bad++;
      end
    end
    m = '0;
    for (int i = 0; i < 8; i++)
      if ((abort_k == 0 || (S + 1) * (i + 1) < abort_k) && tt[i] != e[i]) m[i] = 1'b1;
    cnt_exp = $countones(m);
    ffi_exp = 0;
    for (int i = 7; i >= 0; i--) if (m[i]) ffi_exp = i;
    chk("trace_bad_cycles", bad, 0);
    chk("done_pulses", dones, (abort_k == 0) ? 1 : 0);
    if (abort_k == 0) chk("done_edge", done_at, L);
    chk("fail_mask", fm_w[id], m);
    chk("fail_cnt", cnt_w[id], cnt_exp);
    chk("first_fail_idx", ffi_w[id], ffi_exp);
    chk("pass", pass_w[id], (abort_k == 0 && m == 0) ? 1 : 0);
  endtask

  initial begin : main
    int bad, dones, id, ak;
    logic [7:0] tt;
    for (int i = 0; i < 4; i++) dut_tt[i] = 8'hE8;
    #1;
    chk("reset_state_all", all_outs(0), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    bad = 0; dones = 0;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (all_outs(i) != 0) bad++;
        if (done_w[i]) dones++;
      end
    end
    chk("idle_outputs_zero", bad, 0);
    chk("idle_no_done", dones, 0);
    chk("idle_a", a_w[0], 0);
    chk("idle_busy", busy_w[0], 0);
    chk("idle_fail_mask", fm_w[0], 0);

    run(0, 8'hE8, 0, 0, 1'b1);                        // majority: pass
    run(0, 8'h00, 0, 0, 1'b1);                        // forced 0
    run(1, 8'hE8, 0, 0, 1'b0);                        // only vector 7 differs
    run(0, 8'h00, 15, 0, 1'b1);                       // abort in vector 4 SAMPLE
    run(0, 8'h00, 0, 16, 1'b0);                       // reset during vector 5
    run(0, 8'hE8, 0, 0, 1'b0);
    run(2, 8'hE8, 0, 0, 1'b1);                        // settle 1
    run(3, 8'hE8, 0, 0, 1'b0);                        // settle 15
    run(3, 8'h17, 0, 0, 1'b1);

    for (int r = 0; r < 14; r++) begin
      id = $urandom_range(0, 3);
      tt = 8'($urandom);
      ak = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8 * (s_of(id) + 1)) : 0;
      run(id, tt, ak, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
